// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and helpers for the load/store controller: size codes, FSM states,
// latched request layout, store lane masks and load extension.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sgn;
  } lsu_req_t;

  // Size code 3 is illegal and always reported as an error.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] shifted, input logic [1:0] size,
                                              input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] bx;
    logic signed [31:0] hx;
    b  = shifted[7:0];
    h  = shifted[15:0];
    bx = b;
    hx = h;
    case (size)
      SZ_BYTE: return sgn ? $unsigned(bx) : {24'h0, shifted[7:0]};
      SZ_HALF: return sgn ? $unsigned(hx) : {16'h0, shifted[15:0]};
      default: return shifted;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response handshake plus RAM data port of the load/store controller.
// master = execute stage and RAM side, slave = the controller.
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_signed, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  mem_valid, mem_wen, mem_waddr, mem_wdata, mem_wmask, mem_raddr
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_signed, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_err,
    output mem_valid, mem_wen, mem_waddr, mem_wdata, mem_wmask, mem_raddr
  );
endinterface

// File: rtl/lsu_mem_ctrl_load_align.sv
// Combinational extraction of a byte/half/word from the captured RAM word,
// followed by zero or sign extension to 32 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = word_i >> {off_i, 3'b000};
  assign data_o  = load_extend(shifted, size_i, sgn_i);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store controller in front of the fixed-latency data RAM:
// IDLE accepts, ISSUE strobes the RAM once, WAIT counts latency, RESP holds the answer.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [31:0] ERR_RDATA   = 32'h0000_0000
) (
  input logic           clock,
  input logic           reset,
  lsu_mem_ctrl_if.slave bus
);

  localparam int CNT_W = 3;

  lsu_state_e       state_q, state_d;
  lsu_req_t         req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;

  logic        mis;
  logic [31:0] load_data;

  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;

  assign mis = misaligned(req_q.size, req_q.addr[1:0]);

  lsu_load_align u_align (
    .word_i (rdata_q),
    .off_i  (req_q.addr[1:0]),
    .size_i (req_q.size),
    .sgn_i  (req_q.sgn),
    .data_o (load_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_err   = 1'b0;
    mem_valid  = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          req_d = '{wen:   bus.req_wen,
                    addr:  bus.req_addr,
                    wdata: bus.req_wdata,
                    size:  bus.req_size,
                    sgn:   bus.req_signed};
          // Bad requests skip the RAM entirely and answer with an error.
          state_d = misaligned(bus.req_size, bus.req_addr[1:0]) ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_valid = 1'b1;
        mem_wen   = req_q.wen;
        mem_addr  = {req_q.addr[31:2], 2'b00};
        mem_wdata = req_q.wdata << {req_q.addr[1:0], 3'b000};
        mem_wmask = req_q.wen ? store_mask(req_q.size, req_q.addr[1:0]) : 4'b0000;
        cnt_d     = CNT_W'(MEM_LATENCY - 1);
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = bus.mem_rdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (mis) begin
          resp_err  = 1'b1;
          resp_data = ERR_RDATA;
        end else if (!req_q.wen) begin
          resp_data = load_data;
        end
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = resp_data;
  assign bus.resp_err   = resp_err;
  assign bus.mem_valid  = mem_valid;
  assign bus.mem_wen    = mem_wen;
  assign bus.mem_waddr  = mem_addr;
  assign bus.mem_raddr  = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.mem_wmask  = mem_wmask;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: transaction-level reference model with a fixed-latency RAM,
// directed cases with literal expectations, then randomized traffic.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  localparam int          LAT  = 3;
  localparam logic [31:0] ERRV = 32'hBAD0_0E22;

  logic clock;
  logic reset;
  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(.MEM_LATENCY(LAT), .ERR_RDATA(ERRV)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state: one transaction in flight at most.
  int          cyc;
  bit          busy;
  int          acc_cyc;
  logic        t_wen;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [1:0]  t_size;
  logic        t_sgn;
  bit          t_mis;
  logic [31:0] exp_data;
  logic [31:0] mem_q [16];
  int          rd_due;
  logic [31:0] rd_word;

  logic        drv_valid, drv_wen, drv_sgn, drv_rready;
  logic [31:0] drv_addr, drv_wdata;
  logic [1:0]  drv_size;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit model_mis(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [3:0] model_mask(input logic wen, input logic [31:0] a,
                                            input logic [1:0] sz);
    logic [3:0] m;
    int off, nb;
    m   = 4'b0000;
    off = int'(a % 4);
    nb  = 1 << sz;
    for (int b = 0; b < 4; b++)
      if (wen && b >= off && b < off + nb) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] sz, input logic sg);
    longint v;
    int bits;
    bits = 8 << sz;
    if (bits >= 32) return w;
    v = longint'(w >> (8 * off));
    v = v % (longint'(1) << bits);
    if (sg && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  // 0 idle, 1 issue, 2 wait, 3 resp -- derived from accept time and latency only.
  function automatic int phase_now();
    int t;
    if (!busy) return 0;
    if (t_mis) return 3;
    t = cyc - acc_cyc;
    if (t == 0) return 1;
    if (t <= LAT) return 2;
    return 3;
  endfunction

  task automatic check_outputs();
    int ph;
    ph = phase_now();
    chk("req_ready", bus.req_ready, ph == 0);
    chk("resp_valid", bus.resp_valid, ph == 3);
    chk("mem_valid", bus.mem_valid, ph == 1);
    if (ph == 1) begin
      chk("mem_wen", bus.mem_wen, t_wen);
      chk("mem_waddr", bus.mem_waddr, t_addr & 32'hFFFF_FFFC);
      chk("mem_raddr", bus.mem_raddr, t_addr & 32'hFFFF_FFFC);
      chk("mem_wdata", bus.mem_wdata, t_wdata << (8 * int'(t_addr % 4)));
      chk("mem_wmask", bus.mem_wmask, model_mask(t_wen, t_addr, t_size));
    end
    if (ph == 2) begin
      chk("wait_mem_bus", bus.mem_waddr | bus.mem_raddr | bus.mem_wdata, 32'h0);
      chk("wait_mem_ctl", {bus.mem_wen, bus.mem_wmask}, 32'h0);
    end
    if (ph == 3) begin
      chk("resp_data", bus.resp_data, exp_data);
      chk("resp_err", bus.resp_err, t_mis);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_resp", {bus.resp_valid, bus.resp_err}, 32'h0);
    chk("rst_resp_data", bus.resp_data, 32'h0);
    chk("rst_mem_ctl", {bus.mem_valid, bus.mem_wen, bus.mem_wmask}, 32'h0);
    chk("rst_mem_bus", bus.mem_waddr | bus.mem_raddr | bus.mem_wdata, 32'h0);
  endtask

  // One clock: check at the falling edge, drive, then advance model and RAM at the rising edge.
  task automatic step();
    int ph;
    bit do_acc, do_done;
    logic [3:0] idx;
    @(negedge clock);
    check_outputs();
    bus.req_valid  = drv_valid;
    bus.req_wen    = drv_wen;
    bus.req_addr   = drv_addr;
    bus.req_wdata  = drv_wdata;
    bus.req_size   = drv_size;
    bus.req_signed = drv_sgn;
    bus.resp_ready = drv_rready;
    ph      = phase_now();
    do_acc  = drv_valid && ph == 0;
    do_done = drv_rready && ph == 3;
    if (bus.mem_valid === 1'b1) begin
      if (bus.mem_wen) begin
        idx = bus.mem_waddr[5:2];
        for (int b = 0; b < 4; b++)
          if (bus.mem_wmask[b]) mem_q[idx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
      end else begin
        rd_word = mem_q[bus.mem_raddr[5:2]];
        rd_due  = cyc + LAT;
      end
    end
    @(posedge clock);
    cyc++;
    if (do_done) busy = 0;
    if (do_acc) begin
      busy     = 1;
      acc_cyc  = cyc;
      t_wen    = drv_wen;
      t_addr   = drv_addr;
      t_wdata  = drv_wdata;
      t_size   = drv_size;
      t_sgn    = drv_sgn;
      t_mis    = model_mis(drv_addr, drv_size);
      exp_data = t_mis ? ERRV : t_wen ? 32'h0 :
                 model_load(mem_q[drv_addr[5:2]], drv_addr[1:0], drv_size, drv_sgn);
    end
    #1 bus.mem_rdata = (cyc == rd_due) ? rd_word : $urandom();
  endtask

  task automatic run_tx(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] sz, input logic sg, input int hold,
                        input logic [31:0] lit_data, input logic lit_err, input int lit_lat,
                        input bit chk_iss, input logic [31:0] lit_waddr,
                        input logic [31:0] lit_wdata, input logic [3:0] lit_mask);
    bit seen;
    int held, guard;
    drv_valid = 1; drv_wen = wen; drv_addr = addr; drv_wdata = wdata;
    drv_size = sz; drv_sgn = sg; drv_rready = 0;
    step();
    drv_valid = 0;
    if (chk_iss) begin
      chk("lit_mem_valid", bus.mem_valid, 1'b1);
      chk("lit_mem_wen", bus.mem_wen, wen);
      chk("lit_mem_waddr", bus.mem_waddr, lit_waddr);
      chk("lit_mem_wdata", bus.mem_wdata, lit_wdata);
      chk("lit_mem_wmask", bus.mem_wmask, lit_mask);
    end
    seen = 0; held = 0; guard = 0;
    while (busy && guard < 64) begin
      if (!seen && bus.resp_valid === 1'b1) begin
        seen = 1;
        chk("lit_lat", 32'(cyc - acc_cyc), 32'(lit_lat));
        chk("lit_data", bus.resp_data, lit_data);
        chk("lit_err", bus.resp_err, lit_err);
      end
      if (phase_now() == 3) begin
        drv_rready = (held >= hold);
        held++;
      end else begin
        drv_rready = 0;
      end
      step();
      guard++;
    end
    chk("lit_resp_seen", seen, 1'b1);
    chk("tx_done", busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    cyc = 0; busy = 0; acc_cyc = 0; rd_due = -1; rd_word = '0;
    t_wen = 0; t_addr = '0; t_wdata = '0; t_size = '0; t_sgn = 0; t_mis = 0; exp_data = '0;
    drv_valid = 0; drv_wen = 0; drv_sgn = 0; drv_rready = 0;
    drv_addr = '0; drv_wdata = '0; drv_size = '0;
    bus.req_valid = 0; bus.req_wen = 0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_size = '0; bus.req_signed = 0; bus.resp_ready = 0; bus.mem_rdata = '0;
    for (int i = 0; i < 16; i++) mem_q[i] = $urandom();
    mem_q[0] = 32'h80AB_CDEF;

    repeat (2) @(posedge clock);
    #1 check_reset_outputs();
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;

    run_tx(1, 32'h8000_0004, 32'hDEAD_BEEF, SZ_WORD, 0, 0, 32'h0, 0, 4,
           1, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1111);
    run_tx(1, 32'h8000_0007, 32'h0000_00AB, SZ_BYTE, 0, 2, 32'h0, 0, 4,
           1, 32'h8000_0004, 32'hAB00_0000, 4'b1000);
    run_tx(0, 32'h8000_0004, 32'h0, SZ_WORD, 0, 0, 32'hABAD_BEEF, 0, 4,
           1, 32'h8000_0004, 32'h0, 4'b0000);
    run_tx(0, 32'h8000_0003, 32'h0, SZ_BYTE, 1, 0, 32'hFFFF_FF80, 0, 4,
           1, 32'h8000_0000, 32'h0, 4'b0000);
    run_tx(0, 32'h8000_0003, 32'h0, SZ_BYTE, 0, 1, 32'h0000_0080, 0, 4,
           1, 32'h8000_0000, 32'h0, 4'b0000);
    run_tx(0, 32'h8000_0001, 32'h0, SZ_HALF, 0, 0, ERRV, 1, 0,
           0, 32'h0, 32'h0, 4'b0000);
    mem_q[0] = 32'h7FFF_1234;
    run_tx(0, 32'h8000_0002, 32'h0, SZ_HALF, 1, 5, 32'h0000_7FFF, 0, 4,
           1, 32'h8000_0000, 32'h0, 4'b0000);

    // Abort a word load in WAIT with an asynchronous reset.
    drv_valid = 1; drv_wen = 0; drv_addr = 32'h8000_0000; drv_wdata = '0;
    drv_size = SZ_WORD; drv_sgn = 0; drv_rready = 0;
    step();
    drv_valid = 0;
    step();
    step();
    chk("abort_in_wait", phase_now(), 2);
    @(negedge clock);
    #2 reset = 1'b0;
    bus.req_valid = 0;
    #1 check_reset_outputs();
    busy = 0; rd_due = -1;
    @(posedge clock);
    cyc++;
    #1 bus.mem_rdata = $urandom();
    @(negedge clock);
    check_reset_outputs();
    reset = 1'b1;
    @(posedge clock);
    cyc++;
    #1 bus.mem_rdata = $urandom();
    run_tx(0, 32'h8000_0000, 32'h0, SZ_WORD, 0, 0, 32'h7FFF_1234, 0, 4,
           1, 32'h8000_0000, 32'h0, 4'b0000);

    for (int i = 0; i < 3000; i++) begin
      drv_valid  = ($urandom() % 3) == 0;
      drv_wen    = $urandom() % 2;
      drv_addr   = 32'h8000_0000 | ($urandom() % 64);
      drv_wdata  = $urandom();
      drv_size   = 2'($urandom() % 4);
      drv_sgn    = $urandom() % 2;
      drv_rready = $urandom() % 2;
      step();
    end
    drv_valid = 0; drv_rready = 1;
    for (int g = 0; g < 20 && busy; g++) step();
    chk("drain_done", busy, 1'b0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store controller directly upstream of the DPI-backed data RAM in the NPC core.
- Accepts one load or store request at a time from the execute stage, word-aligns the address and lane-shifts store data into a byte mask.
- Issues a single-cycle access to the RAM data port, then waits a fixed latency for the registered read data.
- Returns an extracted, zero- or sign-extended load value, or a store acknowledge, over a valid/ready response handshake.

Parameters:
- MEM_LATENCY, 1, cycles from the edge sampling mem_valid=1 to the edge after which mem_rdata is valid; legal range 1..7.
- ERR_RDATA, 32'h0000_0000, value driven on resp_data for error responses.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_signed  in  1  sign-extend load result.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  32  extended load data; 0 for stores.
- resp_err  out  1  misaligned access or illegal size.
- mem_valid  out  1  RAM access strobe.
- mem_wen  out  1  RAM write enable.
- mem_waddr  out  32  word-aligned write address.
- mem_wdata  out  32  lane-shifted write data.
- mem_wmask  out  4  byte-lane write mask.
- mem_raddr  out  32  word-aligned read address.
- mem_rdata  in  32  registered RAM read data.

Behaviour:
- Reset (reset=0, asynchronous): state goes to IDLE; all outputs are 0 except req_ready=1; latency counter and latched request are cleared.
- Reset asserted mid-operation aborts the transaction with no response. A write already sampled by RAM at an earlier edge is not undone.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1. A request is accepted on an edge where req_valid=1; all request fields are latched on that edge.
  - Misalignment is decoded on the latched fields: half with addr[0]=1, word with addr[1:0]!=0, or size=3.
  - A misaligned request goes IDLE->RESP with resp_err=1, resp_data=ERR_RDATA, and no memory access.
  - An aligned request goes IDLE->ISSUE.
- ISSUE:
  - Exactly one cycle. mem_valid=1 and mem_wen=latched wen.
  - mem_raddr = mem_waddr = {addr[31:2],2'b00}.
  - mem_wdata = wdata shifted left by 8*addr[1:0].
  - mem_wmask: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111. The mask is 0 for loads.
  - Next state is WAIT, with the counter loaded to MEM_LATENCY-1.
- WAIT:
  - mem_valid=0 and all other mem_* outputs are 0.
  - The counter decrements each cycle. When it is 0 at a clock edge, mem_rdata is captured and the state goes to RESP.
  - With MEM_LATENCY=1 the WAIT state lasts one cycle.
- Load extraction from the captured word:
  - shifted = word >> 8*addr[1:0]; the low 8 or 16 bits are taken for byte or half.
  - If req_signed=1 the result is sign-extended, otherwise zero-extended. A word load is passed through unchanged.
- RESP:
  - resp_valid=1; resp_data and resp_err are held stable until resp_ready=1 at an edge, then the state goes to IDLE.
  - req_ready=0 throughout RESP; there is no same-cycle re-accept.
  - Stores return resp_data=0, resp_err=0.
- Latency: an aligned request with MEM_LATENCY=1 gives resp_valid in the 3rd cycle after the accept edge (ISSUE, WAIT, RESP).
- Back-pressure: resp_ready held low keeps the controller in RESP indefinitely; mem_valid stays 0.
- Store while resp_ready=1 is already high: the response completes in one RESP cycle.

Decomposition:
- Shared package lsu_pkg holds:
  - the size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum;
  - functions for mask generation and load extension.
- One natural sub-module: lsu_load_align (combinational extract/extend of the captured word by addr[1:0], size and signed).

Test Plan:
- Word store, addr 0x8000_0004, wdata 0xDEADBEEF -> ISSUE cycle shows mem_wen=1, waddr 0x8000_0004, mask 4'b1111, wdata 0xDEADBEEF; then resp_valid with data 0, err 0.
- Byte store, addr 0x8000_0007, wdata 0x0000_00AB -> mask 4'b1000, mem_wdata 0xAB00_0000.
- Signed byte load, addr 0x8000_0003, mem_rdata 0x80xx_xxxx -> resp_data 0xFFFF_FF80; the same load unsigned -> 0x0000_0080.
- Half load, addr 0x8000_0001 -> resp_err=1, resp_data=ERR_RDATA, mem_valid never asserted.
- Signed half load, addr 0x8000_0002, mem_rdata 0x7FFF_1234 -> resp_data 0x0000_7FFF; hold resp_ready=0 for 5 cycles -> resp_valid and resp_data stable and req_ready=0 throughout.
- With MEM_LATENCY=3, issue a word load, then assert reset low during WAIT -> all outputs 0 immediately and req_ready=1. After release, a new load of 0x8000_0000 returns mem_rdata with resp_valid 5 cycles after accept.
